// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
//   Turns each rising edge on step_in into one stepper-driver pulse. Each pulse
//   has a guaranteed direction setup time, a fixed high width and a minimum low
//   width. One step request can wait in a buffer while a pulse is in progress.
//   Issued steps are counted into a signed position. Any step edge that arrives
//   while the buffer is already full is dropped, and the sticky overrun flag
//   records it.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   step_in        step request level (a rising edge requests one step)
//   dir_in         direction, sampled together with the step edge
//   overrun_clr    clears overrun (a drop in the same cycle wins)
//   pos_load       loads pos_load_val into position (wins over a step update)
//   pos_load_val   position preload value
//   step_out       driver step pin
//   dir_out        driver direction pin
//   busy           FSM not idle, or a request is pending
//   overrun        sticky: a step edge was dropped
//   position       signed step count, wraps modulo 2^32
module step_pulse_shaper #(
    parameter int unsigned DIR_SETUP = 20,
    parameter int unsigned STEP_HIGH = 100,
    parameter int unsigned STEP_LOW  = 100,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        overrun_clr,
    input  logic        pos_load,
    input  logic [31:0] pos_load_val,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic        overrun,
    output logic [31:0] position
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(STEP_LOW - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_prev_q, step_prev_d;
    logic              step_out_q, step_out_d;
    logic              dir_out_q, dir_out_d;
    logic              pend_v_q, pend_v_d;
    logic              pend_dir_q, pend_dir_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       position_q, position_d;

    logic              edge_w;
    logic              req_v;
    logic              req_dir;
    logic              req_chg;
    logic              cnt_zero;

    assign edge_w   = step_in & ~step_prev_q;
    assign cnt_zero = (cnt_q == '0);
    assign req_chg  = (req_dir != dir_out_q);

    // Request seen by IDLE. The buffered entry takes priority over a fresh edge.
    always_comb begin
        req_v   = 1'b0;
        req_dir = dir_in;
        if (state_q == S_IDLE) begin
            if (pend_v_q) begin
                req_v   = 1'b1;
                req_dir = pend_dir_q;
            end else if (edge_w) begin
                req_v   = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
            step_out_q  <= 1'b0;
            dir_out_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_dir_q  <= 1'b0;
            overrun_q   <= 1'b0;
            position_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_prev_q <= step_prev_d;
            step_out_q  <= step_out_d;
            dir_out_q   <= dir_out_d;
            pend_v_q    <= pend_v_d;
            pend_dir_q  <= pend_dir_d;
            overrun_q   <= overrun_d;
            position_q  <= position_d;
        end
    end

    // Next state and the shared down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_v) begin
                    if (req_chg) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = HIGH_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_zero) begin
                    state_d = S_LOW;
                    cnt_d   = LOW_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs, request buffer, overrun flag and position
    always_comb begin
        logic drop;
        logic pos_step;

        step_prev_d = step_in;
        step_out_d  = step_out_q;
        dir_out_d   = dir_out_q;
        pend_v_d    = pend_v_q;
        pend_dir_d  = pend_dir_q;
        overrun_d   = overrun_q;
        position_d  = position_q;
        drop        = 1'b0;
        pos_step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_v) begin
                    if (req_chg) dir_out_d  = req_dir;
                    else         step_out_d = 1'b1;
                end
            end
            S_SETUP: if (cnt_zero) step_out_d = 1'b1;
            S_HIGH: begin
                if (cnt_zero) begin
                    step_out_d = 1'b0;
                    pos_step   = 1'b1;
                end
            end
            default: ;
        endcase

        // In IDLE, a pending entry is consumed this cycle, so a coincident
        // edge refills the buffer instead of overflowing it. A fresh edge with
        // nothing pending goes straight to the FSM.
        if (state_q == S_IDLE) begin
            if (pend_v_q) begin
                pend_v_d = edge_w;
                if (edge_w) pend_dir_d = dir_in;
            end
        end else if (edge_w) begin
            if (pend_v_q) begin
                drop = 1'b1;
            end else begin
                pend_v_d   = 1'b1;
                pend_dir_d = dir_in;
            end
        end

        if (overrun_clr) overrun_d = 1'b0;
        if (drop)        overrun_d = 1'b1;

        if (pos_load)      position_d = pos_load_val;
        else if (pos_step) position_d = dir_out_q ? position_q + 32'd1
                                                  : position_q - 32'd1;
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign busy     = (state_q != S_IDLE) || pend_v_q;
    assign overrun  = overrun_q;
    assign position = position_q;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed testbench for step_pulse_shaper using the default parameters.
// Inputs change on the falling clock edge. Outputs are observed on the falling
// edge, which is half a cycle after the active edge.
module tb_step_pulse_shaper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_in = 1'b0;
    logic        dir_in = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        pos_load = 1'b0;
    logic [31:0] pos_load_val = '0;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        overrun;
    logic [31:0] position;

    int nchk = 0;
    int nbad = 0;

    step_pulse_shaper #(
        .DIR_SETUP(20),
        .STEP_HIGH(100),
        .STEP_LOW(100),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .step_in(step_in),
        .dir_in(dir_in),
        .overrun_clr(overrun_clr),
        .pos_load(pos_load),
        .pos_load_val(pos_load_val),
        .step_out(step_out),
        .dir_out(dir_out),
        .busy(busy),
        .overrun(overrun),
        .position(position)
    );

    always #5 clk = ~clk;

    // Cycle index: incremented on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor. It records the cycle of each step_out rise, the high
    // width of the last pulse and the cycle of the last dir_out change.
    int   pulses = 0;
    int   rise_at [0:15];
    int   last_rise = 0;
    int   last_high = 0;
    int   dir_chg_cyc = 0;
    logic so_prev = 1'b0;
    logic dir_prev = 1'b0;
    always @(negedge clk) begin
        if (step_out && !so_prev) begin
            last_rise = cyc;
            rise_at[pulses % 16] = cyc;
            pulses = pulses + 1;
        end
        if (!step_out && so_prev) last_high = cyc - last_rise;
        if (dir_out != dir_prev) dir_chg_cyc = cyc;
        so_prev  = step_out;
        dir_prev = dir_out;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk = nchk + 1;
        if (act !== exp) begin
            nbad = nbad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step_in = 1'b0;
        dir_in = 1'b0;
        overrun_clr = 1'b0;
        pos_load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives a one-cycle step_in pulse. n is the rising edge that samples it.
    task automatic pulse_step(input logic d, output int n);
        @(negedge clk);
        step_in = 1'b1;
        dir_in  = d;
        n = cyc + 1;
        @(negedge clk);
        step_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, n2, p0;

        // 1: reset values, then one step with dir 0
        do_reset();
        @(negedge clk);
        chk("rst_step_out", 32'(step_out), 32'd0);
        chk("rst_dir_out",  32'(dir_out),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        chk("rst_position", position,      32'd0);
        p0 = pulses;
        pulse_step(1'b0, n);
        wait_idle("t1_idle", 400);
        chk("t1_rise",   32'(last_rise), 32'(n));
        chk("t1_high",   32'(last_high), 32'd100);
        chk("t1_dir",    32'(dir_out),   32'd0);
        chk("t1_pos",    position,       32'hFFFF_FFFF);
        chk("t1_pulses", 32'(pulses - p0), 32'd1);

        // 2: direction change costs DIR_SETUP before the rise
        do_reset();
        pulse_step(1'b1, n);
        wait_idle("t2_idle", 500);
        chk("t2_dir_chg", 32'(dir_chg_cyc), 32'(n));
        chk("t2_rise",    32'(last_rise),   32'(n + 20));
        chk("t2_high",    32'(last_high),   32'd100);
        chk("t2_dir",     32'(dir_out),     32'd1);
        chk("t2_pos",     position,         32'd1);

        // 3: a second edge 10 cycles later is buffered
        do_reset();
        p0 = pulses;
        pulse_step(1'b0, n);
        repeat (8) @(negedge clk);
        pulse_step(1'b0, n2);
        chk("t3_n2",     32'(n2 - n), 32'd10);
        chk("t3_busy",   32'(busy),   32'd1);
        wait_idle("t3_idle", 800);
        chk("t3_rise1",  32'(rise_at[p0 % 16]), 32'(n));
        chk("t3_period", 32'(rise_at[(p0 + 1) % 16] - rise_at[p0 % 16]), 32'd201);
        chk("t3_pulses", 32'(pulses - p0), 32'd2);
        chk("t3_ovr",    32'(overrun),     32'd0);
        chk("t3_pos",    position,         32'hFFFF_FFFE);

        // 4: a third edge is dropped; a clear in the same cycle as a drop loses
        do_reset();
        p0 = pulses;
        pulse_step(1'b0, n);
        repeat (8) @(negedge clk);
        pulse_step(1'b0, n2);
        chk("t4_ovr_pre", 32'(overrun), 32'd0);
        repeat (8) @(negedge clk);
        pulse_step(1'b0, n2);
        chk("t4_ovr_set", 32'(overrun), 32'd1);
        @(negedge clk);
        step_in = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        overrun_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun), 32'd1);
        wait_idle("t4_idle", 1000);
        chk("t4_pulses", 32'(pulses - p0), 32'd2);
        chk("t4_pos",    position,         32'hFFFF_FFFE);
        chk("t4_sticky", 32'(overrun),     32'd1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'd0);

        // 5: wrap past 0x7FFFFFFF, then a load coinciding with the HIGH->LOW edge
        do_reset();
        @(negedge clk);
        pos_load = 1'b1;
        pos_load_val = 32'h7FFF_FFFF;
        @(negedge clk);
        pos_load = 1'b0;
        chk("t5_loaded", position, 32'h7FFF_FFFF);
        pulse_step(1'b1, n);
        wait_idle("t5_idle", 500);
        chk("t5_wrap", position, 32'h8000_0000);
        pulse_step(1'b1, n);
        repeat (99) @(negedge clk);
        chk("t5_still_high", 32'(step_out), 32'd1);
        pos_load = 1'b1;
        pos_load_val = 32'h1234_5678;
        @(negedge clk);
        pos_load = 1'b0;
        chk("t5_fell",     32'(step_out), 32'd0);
        chk("t5_load_win", position,      32'h1234_5678);
        wait_idle("t5_idle2", 300);
        chk("t5_load_kept", position, 32'h1234_5678);

        // 6: asynchronous reset mid-pulse with an entry pending
        do_reset();
        p0 = pulses;
        pulse_step(1'b0, n);
        repeat (8) @(negedge clk);
        pulse_step(1'b0, n2);
        repeat (40) @(negedge clk);
        chk("t6_high_before", 32'(step_out), 32'd1);
        chk("t6_pend_busy",   32'(busy),     32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_step_out", 32'(step_out), 32'd0);
        chk("t6_position", position,      32'd0);
        chk("t6_busy",     32'(busy),     32'd0);
        chk("t6_overrun",  32'(overrun),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("t6_no_pulse", 32'(pulses - p0), 32'd1);
        chk("t6_idle",     32'(busy),        32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/step_pulse_shaper.md
# step_pulse_shaper

Sits directly downstream of the motor mux, between the muxed `step`/`dir` pair and the external stepper driver pins. Turns each rising edge on `step_in` into a clean driver pulse with guaranteed direction setup, minimum high and low widths, and a one-deep request buffer. Tracks the motor position in issued steps. Flags any step edges it had to drop.

## Interface
Parameters:
- `DIR_SETUP`, default 20: cycles `dir_out` must be stable before `step_out` rises after a direction change (≥1).
- `STEP_HIGH`, default 100: `step_out` high width in cycles (≥1).
- `STEP_LOW`, default 100: minimum `step_out` low time after each pulse; also the direction hold time (≥1).
- `CNT_W`, default 16: timer width. All three timing parameters must be ≤ 2^CNT_W−1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `step_in`  in  1  step request from the mux (level; rising edge = one step).
- `dir_in`  in  1  direction from the mux, sampled together with the step edge.
- `overrun_clr`  in  1  clears `overrun`.
- `pos_load`  in  1  loads `pos_load_val` into `position`.
- `pos_load_val`  in  32  position preload value.
- `step_out`  out  1  step pin to the driver.
- `dir_out`  out  1  direction pin to the driver.
- `busy`  out  1  high when the FSM is not IDLE or a request is pending.
- `overrun`  out  1  sticky flag: a step edge was dropped.
- `position`  out  32  signed step position.

## Operation
- Edge detect: `edge = step_in & ~step_prev`. `step_prev` is a register with reset value 0.
- Pending buffer `{pend_v, pend_dir}`:
  - On `edge`, when the FSM cannot accept it this cycle, `pend_v` is set to 1 and `pend_dir` captures `dir_in`.
  - If `pend_v` is already 1, the edge is dropped and `overrun` is set to 1.
- FSM states: IDLE, SETUP, HIGH, LOW. A single down-counter `cnt[CNT_W-1:0]` serves all timed states.
- IDLE:
  - Request source: the pending entry takes priority, otherwise a new `edge`.
  - The request's direction is `d` (`pend_dir` or `dir_in`). Accepting a pending entry clears `pend_v`. A simultaneous new edge then fills the buffer.
  - If `d != dir_out`: `dir_out <= d`, `cnt <= DIR_SETUP-1`, go to SETUP.
  - Otherwise: `step_out <= 1`, `cnt <= STEP_HIGH-1`, go to HIGH.
- SETUP: when `cnt == 0`, `step_out <= 1`, `cnt <= STEP_HIGH-1`, go to HIGH; otherwise decrement `cnt`.
- HIGH: when `cnt == 0`:
  - `step_out <= 0`, `cnt <= STEP_LOW-1`, go to LOW.
  - `position` is incremented if `dir_out == 1`, decremented if `dir_out == 0`. It wraps modulo 2^32.
- LOW: when `cnt == 0`, go to IDLE; otherwise decrement `cnt`.
- `dir_out` changes only on the IDLE→SETUP transition. It never changes during HIGH or LOW, which guarantees the hold time.
- Simultaneous `pos_load` and position update: `pos_load` wins and the step is not counted.
- Simultaneous `overrun_clr` and a dropped edge: `overrun` stays 1 (set wins).
- Reset values: `step_out` 0, `dir_out` 0, `busy` 0, `overrun` 0, `position` 0, `pend_v` 0, state IDLE, `cnt` 0.
- Reset mid-pulse: `step_out` drops immediately (asynchronous) and all state is cleared. The pending entry is lost and is not flagged as an overrun.

## Timing
- Edge first sampled at clock edge n, direction unchanged: `step_out` high from n+1 for exactly STEP_HIGH cycles.
- Edge at n with a direction change: `dir_out` toggles at n+1, and `step_out` rises at n+1+DIR_SETUP.
- After `step_out` falls, it stays low for STEP_LOW cycles plus 1 IDLE cycle.
  - Minimum step period, same direction: STEP_HIGH+STEP_LOW+1.
  - Minimum step period with a direction change: add DIR_SETUP.
- `position` updates on the same edge that `step_out` falls.
- `busy` is registered-state derived (combinational from state and `pend_v`). It has no extra latency.
- `overrun` is set on the cycle after the dropped edge is sampled.

## Test plan
Default parameters unless noted.
- Reset, then a single `step_in` pulse with `dir_in=0`: `step_out` high 100 cycles starting 1 cycle after the edge, `dir_out` stays 0, `position` = −1, `busy` then drops.
- `step_in` edge with `dir_in=1` from `dir_out=0`: `dir_out` rises at n+1, `step_out` rises at n+21 and is high 100 cycles, `position` = +1.
- Two edges 10 cycles apart, same direction: the second pulse is buffered. Its `step_out` rise is exactly 201 cycles after the first rise, `overrun` stays 0, `position` = ±2.
- Three edges within 50 cycles: third is dropped, `overrun`=1, only 2 pulses emitted. Then `overrun_clr` → `overrun` 0.
- `pos_load` of 0x7FFFFFFF followed by one positive step: `position` = 0x80000000 (wrap). `pos_load` in the same cycle as the HIGH→LOW transition → loaded value is kept.
- `rst_n` asserted 50 cycles into HIGH with an entry pending: `step_out` 0 immediately, `position` 0, after release no further pulse is emitted.
